// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
// Bundles the pipeline-side signals of the hazard controller.
//   slave  : used by hazard_unit. It reads the ID/EX hazard sources, the branch
//            and memory status, and drives the enable and flush controls.
//   master : used by the pipeline or the bench. It drives the sources and
//            reads the controls.
// Signals:
//   id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used : ID-stage source regs
//   id_ex_reg_addr, id_ex_mem_rd, id_ex_reg_wr_ena   : EX-stage destination
//   branch_taken, mem_busy                           : control events
//   pc_wr_ena, if_id_wr_ena, id_ex_wr_ena, ex_mem_wr_ena : register enables
//   if_id_flush, id_ex_flush                         : NOP injection
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_addr;
  logic                      id_ex_mem_rd;
  logic                      id_ex_reg_wr_ena;
  logic                      branch_taken;
  logic                      mem_busy;
  logic                      pc_wr_ena;
  logic                      if_id_wr_ena;
  logic                      id_ex_wr_ena;
  logic                      ex_mem_wr_ena;
  logic                      if_id_flush;
  logic                      id_ex_flush;

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  id_ex_reg_addr, id_ex_mem_rd, id_ex_reg_wr_ena,
    input  branch_taken, mem_busy,
    output pc_wr_ena, if_id_wr_ena, id_ex_wr_ena, ex_mem_wr_ena,
    output if_id_flush, id_ex_flush
  );

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output id_ex_reg_addr, id_ex_mem_rd, id_ex_reg_wr_ena,
    output branch_taken, mem_busy,
    input  pc_wr_ena, if_id_wr_ena, id_ex_wr_ena, ex_mem_wr_ena,
    input  if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the 5-stage DLX pipeline. It detects load-use hazards
// between ID and EX and inserts LOAD_LATENCY bubbles. It flushes IF/ID and
// ID/EX on a taken branch or jump, and freezes every pipeline register while
// data memory is busy.
// Ports:
//   clk        : core clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : hazard_unit_if.slave (hazard sources in, enables/flushes out)
//   stall_cnt  : stall-cycle counter   (only with HAZARD_PERF_CNT_EN)
//   flush_cnt  : branch-flush counter  (only with HAZARD_PERF_CNT_EN)
// Parameters:
//   REG_ADDR_WIDTH : register address width
//   LOAD_LATENCY   : bubbles per load-use hazard, 1..7
//   CNT_WIDTH      : performance counter width
// Optional feature macro: HAZARD_PERF_CNT_EN adds the performance counters.
// Output priority: reset > freeze > branch > load stall > normal.
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LATENCY   = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_unit_if.slave         bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

  // Parameter sanity: these empty blocks only elaborate for illegal values,
  // so they show up by name in the elaborated hierarchy.
  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 7) begin : g_bad_load_latency
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
  end

  typedef enum logic {
    S_RUN        = 1'b0,
    S_LOAD_STALL = 1'b1
  } state_t;

  // Bubble count still owed after the hazard cycle itself.
  localparam logic [2:0] BCNT_START = 3'(LOAD_LATENCY - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_bcnt;
  logic [2:0] w_bcnt_next;
  logic       w_hz;
  logic       w_stall;

  // Load-use hazard. Register 0 is hard-wired, so it never creates one.
  always_comb begin
    w_hz = bus.id_ex_mem_rd & bus.id_ex_reg_wr_ena &
           (bus.id_ex_reg_addr != {REG_ADDR_WIDTH{1'b0}}) &
           ((bus.id_rs1_used & (bus.id_rs1_addr == bus.id_ex_reg_addr)) |
            (bus.id_rs2_used & (bus.id_rs2_addr == bus.id_ex_reg_addr)));
  end

  // LOAD_STALL keeps stalling no matter what hz says. The load has already
  // left EX, so hz no longer describes the instruction being protected.
  assign w_stall = (r_state == S_LOAD_STALL) | w_hz;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_bcnt  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_bcnt  <= w_bcnt_next;
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_next      = r_state;
    w_bcnt_next       = r_bcnt;
    bus.pc_wr_ena     = 1'b1;
    bus.if_id_wr_ena  = 1'b1;
    bus.id_ex_wr_ena  = 1'b1;
    bus.ex_mem_wr_ena = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;

    if (rst) begin
      // Keep the pipeline moving so that it fills with NOPs.
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (bus.mem_busy) begin
      // Freeze: nothing moves, and the stall bookkeeping holds.
      bus.pc_wr_ena     = 1'b0;
      bus.if_id_wr_ena  = 1'b0;
      bus.id_ex_wr_ena  = 1'b0;
      bus.ex_mem_wr_ena = 1'b0;
    end else if (bus.branch_taken) begin
      // The wrong-path instructions in IF/ID and ID/EX are squashed. Any
      // pending load stall is moot because its dependent is squashed too.
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
      w_state_next    = S_RUN;
      w_bcnt_next     = 3'd0;
    end else if (w_stall) begin
      // Hold PC and IF/ID. Send a bubble into EX and let the load move on.
      bus.pc_wr_ena    = 1'b0;
      bus.if_id_wr_ena = 1'b0;
      bus.id_ex_flush  = 1'b1;
      if (r_state == S_RUN) begin
        if (LOAD_LATENCY > 1) begin
          w_state_next = S_LOAD_STALL;
          w_bcnt_next  = BCNT_START;
        end
      end else begin
        w_bcnt_next = r_bcnt - 3'd1;
        if (r_bcnt == 3'd1) begin
          w_state_next = S_RUN;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  // Counting while frozen is excluded. A freeze leaves pc_wr_ena low without
  // spending a bubble, so it must not count as a stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!bus.mem_busy) begin
      if (!bus.pc_wr_ena) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (bus.branch_taken) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Runs two hazard_unit instances side by side, one with LOAD_LATENCY=1 and one
// with LOAD_LATENCY=3, on the same directed stimulus. A bubbles-owed model
// predicts each instance's outputs on every cycle. Literal checks at key
// points pin that model down.
// -----------------------------------------------------------------------------
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_ADDR_WIDTH(5)) bus1 ();
  hazard_unit_if #(.REG_ADDR_WIDTH(5)) bus3 ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  hazard_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(1), .CNT_WIDTH(32)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (sc1),
    .flush_cnt (fc1)
`endif
  );

  hazard_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(3), .CNT_WIDTH(32)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (sc3),
    .flush_cnt (fc3)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- model ----------------
  int          m_lat  [2] = '{1, 3};
  int          m_rem  [2] = '{0, 0};   // stall cycles still owed after this one
  int unsigned m_stall[2] = '{0, 0};
  int unsigned m_flush[2] = '{0, 0};

  function automatic logic model_hz();
    logic dep1, dep2;
    dep1 = bus1.id_rs1_used && (bus1.id_rs1_addr == bus1.id_ex_reg_addr);
    dep2 = bus1.id_rs2_used && (bus1.id_rs2_addr == bus1.id_ex_reg_addr);
    return bus1.id_ex_mem_rd && bus1.id_ex_reg_wr_ena &&
           (bus1.id_ex_reg_addr != 5'd0) && (dep1 || dep2);
  endfunction

  // Bit order: {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush}
  function automatic logic [5:0] model_out(int k);
    if (rst)                          return 6'b111111;
    if (bus1.mem_busy)                return 6'b000000;
    if (bus1.branch_taken)            return 6'b111111;
    if (m_rem[k] > 0 || model_hz())   return 6'b001101;
    return 6'b111100;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else if (bus1.mem_busy) begin
        // frozen: nothing changes
      end else if (bus1.branch_taken) begin
        m_rem[k] = 0;
        m_flush[k]++;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
        m_stall[k]++;
      end else if (model_hz()) begin
        m_rem[k] = m_lat[k] - 1;
        m_stall[k]++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] a1, a3;
    a1 = {bus1.pc_wr_ena, bus1.if_id_wr_ena, bus1.id_ex_wr_ena,
          bus1.ex_mem_wr_ena, bus1.if_id_flush, bus1.id_ex_flush};
    a3 = {bus3.pc_wr_ena, bus3.if_id_wr_ena, bus3.id_ex_wr_ena,
          bus3.ex_mem_wr_ena, bus3.if_id_flush, bus3.id_ex_flush};
    cmp("model_ctrl_lat1", 32'(a1), 32'(model_out(0)));
    cmp("model_ctrl_lat3", 32'(a3), 32'(model_out(1)));
`ifdef HAZARD_PERF_CNT_EN
    cmp("model_stall_cnt_lat1", sc1, m_stall[0]);
    cmp("model_flush_cnt_lat1", fc1, m_flush[0]);
    cmp("model_stall_cnt_lat3", sc3, m_stall[1]);
    cmp("model_flush_cnt_lat3", fc3, m_flush[1]);
`endif
  end

  // ---------------- stimulus ----------------
  // Apply a vector just after a rising edge, then wait for the sampling edge.
  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] exa,
                       input logic mrd, input logic wr, input logic br, input logic busy);
    @(posedge clk);
    #1;
    rst = r;
    bus1.id_rs1_addr = rs1;  bus3.id_rs1_addr = rs1;
    bus1.id_rs2_addr = rs2;  bus3.id_rs2_addr = rs2;
    bus1.id_rs1_used = u1;   bus3.id_rs1_used = u1;
    bus1.id_rs2_used = u2;   bus3.id_rs2_used = u2;
    bus1.id_ex_reg_addr = exa;     bus3.id_ex_reg_addr = exa;
    bus1.id_ex_mem_rd = mrd;       bus3.id_ex_mem_rd = mrd;
    bus1.id_ex_reg_wr_ena = wr;    bus3.id_ex_reg_wr_ena = wr;
    bus1.branch_taken = br;        bus3.branch_taken = br;
    bus1.mem_busy = busy;          bus3.mem_busy = busy;
    @(negedge clk);
  endtask

  task automatic nop(input logic busy = 1'b0);
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, busy);
  endtask

  // Load to r5 in EX and ID reading r5 through rs2
  task automatic hz_r5(input logic br = 1'b0);
    drive(1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, br, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("rst_if_id_flush", 32'(bus3.if_id_flush), 32'd1);
    cmp("rst_id_ex_flush", 32'(bus1.id_ex_flush), 32'd1);
    cmp("rst_pc_wr_ena",   32'(bus3.pc_wr_ena),   32'd1);
    nop();
    cmp("normal_pc", 32'(bus1.pc_wr_ena), 32'd1);
    cmp("normal_flush", 32'(bus3.id_ex_flush), 32'd0);

    // Load-use through rs2: one bubble for LAT1, three for LAT3
    hz_r5();
    cmp("hz_lat1_pc",    32'(bus1.pc_wr_ena),    32'd0);
    cmp("hz_lat1_ifid",  32'(bus1.if_id_wr_ena), 32'd0);
    cmp("hz_lat1_flush", 32'(bus1.id_ex_flush),  32'd1);
    cmp("hz_lat3_pc",    32'(bus3.pc_wr_ena),    32'd0);
    nop();
    cmp("hz_lat1_after", 32'(bus1.pc_wr_ena), 32'd1);
    cmp("hz_lat3_b2",    32'(bus3.pc_wr_ena), 32'd0);
    nop();
    cmp("hz_lat3_b3",    32'(bus3.pc_wr_ena), 32'd0);
    nop();
    cmp("hz_lat3_done",  32'(bus3.pc_wr_ena), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    cmp("lit_stall_cnt_lat3", sc3, 32'd3);
    cmp("lit_stall_cnt_lat1", sc1, 32'd1);
`endif

    // Register 0 and an unused rs1 never stall
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("r0_no_stall", 32'(bus3.pc_wr_ena), 32'd1);
    drive(1'b0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("unused_rs1_no_stall", 32'(bus3.pc_wr_ena), 32'd1);
    // A dependency on rs1 does stall
    drive(1'b0, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("rs1_stall", 32'(bus1.pc_wr_ena), 32'd0);
    nop(); nop(); nop();

    // Branch in the same cycle as a hazard
    hz_r5(1'b1);
    cmp("br_hz_ifid_flush", 32'(bus3.if_id_flush), 32'd1);
    cmp("br_hz_idex_flush", 32'(bus3.id_ex_flush), 32'd1);
    cmp("br_hz_pc",         32'(bus3.pc_wr_ena),   32'd1);
    nop();
    cmp("br_hz_then_run",   32'(bus3.pc_wr_ena),   32'd1);
    cmp("br_one_flush",     32'(bus3.if_id_flush), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    cmp("lit_flush_cnt", fc3, 32'd1);
`endif

    // Freeze for 4 cycles during the second cycle of a 3-bubble stall
    hz_r5();
    for (int i = 0; i < 4; i++) begin
      nop(1'b1);
      cmp("freeze_pc",     32'(bus3.pc_wr_ena),     32'd0);
      cmp("freeze_exmem",  32'(bus1.ex_mem_wr_ena), 32'd0);
      cmp("freeze_flush",  32'(bus3.id_ex_flush),   32'd0);
    end
    nop();
    cmp("post_freeze_b2",   32'(bus3.pc_wr_ena), 32'd0);
    cmp("post_freeze_lat1", 32'(bus1.pc_wr_ena), 32'd1);
    nop();
    cmp("post_freeze_b3",   32'(bus3.pc_wr_ena), 32'd0);
    nop();
    cmp("post_freeze_run",  32'(bus3.pc_wr_ena), 32'd1);

    // A branch aborts a stall in progress
    hz_r5();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("abort_flush", 32'(bus3.if_id_flush), 32'd1);
    nop();
    cmp("abort_run",   32'(bus3.pc_wr_ena),   32'd1);

    // Reset in the middle of a stall
    hz_r5();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("rst_mid_if_flush", 32'(bus3.if_id_flush), 32'd1);
    cmp("rst_mid_id_flush", 32'(bus3.id_ex_flush), 32'd1);
    nop();
    cmp("rst_mid_run", 32'(bus3.pc_wr_ena), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    cmp("lit_rst_stall_cnt", sc3, 32'd0);
    cmp("lit_rst_flush_cnt", fc3, 32'd0);
`endif
    nop(); nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
